// File: rtl/rvr32_lsu.sv
// rtl/rvr32_lsu.sv - rvr32 load/store unit: one request at a time to a single word-aligned bus access
// Lane-replicated stores, byte/half extraction with sign/zero extension, misalign and timeout errors.
module rvr32_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             mem_valid,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] cnt;

  logic        misaligned;
  logic        timed_out;
  logic [31:0] st_wdata;
  logic [3:0]  st_strb;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  always_comb begin
    misaligned = (req_size == 2'b11) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && (req_addr[1:0] != 2'b00));
    timed_out  = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
  end

  always_comb begin
    st_wdata = req_wdata;
    st_strb  = 4'b1111;
    case (req_size)
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_strb  = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_strb  = 4'b0011 << req_addr[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_b   = mem_rdata[{off_q, 3'b000} +: 8];
    ld_h   = mem_rdata[{off_q[1], 4'b0000} +: 16];
    ld_ext = mem_rdata;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_ext = uns_q ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = misaligned ? S_RESP : S_BUS;
      end
      S_BUS: begin
        mem_valid = 1'b1;
        if (mem_ready || timed_out) state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus-side outputs are captured once at accept so they stay constant across the whole BUS state.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      off_q     <= 2'b00;
      cnt       <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            off_q     <= req_addr[1:0];
            cnt       <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_tag   <= req_tag;
            rsp_err   <= misaligned;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_wstrb <= req_we ? st_strb : 4'b0000;
          end
        end
        S_BUS: begin
          cnt <= cnt + 32'd1;
          if (mem_ready)      rsp_rdata <= we_q ? 32'd0 : ld_ext;
          else if (timed_out) rsp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
